// File: rtl/vga_pkg.sv
// Shared VGA-path types: display modes, colour constants and per-pixel side-band flags.
package vga_pkg;

  typedef enum logic [1:0] {
    MODO_DIRECT = 2'b00,
    MODO_INVERT = 2'b01,
    MODO_BLINK  = 2'b10
  } modo_t;

  typedef logic [23:0] rgb_t;  // {red, green, blue}

  localparam rgb_t COLOR_BLACK = 24'h000000;
  localparam rgb_t COLOR_WHITE = 24'hFFFFFF;

  // Flags that travel alongside a pixel so the colour stage sees the
  // state that was valid when that pixel was sampled.
  typedef struct packed {
    logic vis;  // active video
    logic win;  // inside the framebuffer window (implies vis)
    logic inv;  // complement the fetched bits
    logic brd;  // blink-off phase: paint window with border colour
  } pix_flags_t;

  localparam int PIX_FLAGS_W = $bits(pix_flags_t);

  // 3-bit framebuffer pixel to full-scale 24-bit colour; bit0 red, bit1 green, bit2 blue.
  function automatic rgb_t expand_rgb(input logic [2:0] bits);
    return {{8{bits[0]}}, {8{bits[1]}}, {8{bits[2]}}};
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register; synchronous active-low clear. DEPTH must be >= 1.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  // Shift one stage per clock; clear every stage on reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/region_pantalla_param.sv
// Screen-region colouriser: maps raster position into a scaled, offset framebuffer
// window, fetches the pixel and aligns it with latency-matched flags.
// Colour latency from posicion to red/green/blue is 2+MEM_LATENCY on every path.
module region_pantalla_param
  import vga_pkg::*;
#(
  parameter int          SCREEN_X     = 50,
  parameter int          SCREEN_Y     = 50,
  parameter int          ORIGIN_X     = 0,
  parameter int          ORIGIN_Y     = 0,
  parameter int          SCALE_LOG2   = 0,
  parameter int          MEM_LATENCY  = 1,
  parameter int          ADDR_W       = 12,
  parameter logic [23:0] BORDER_COLOR = 24'hFFFFFF,
  parameter int          BLINK_LOG2   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [9:0]        posicionX,
  input  logic [9:0]        posicionY,
  input  logic              visible,
  input  logic [1:0]        modo,
  output logic [ADDR_W-1:0] memAddress,
  input  logic [2:0]        readValueMemory,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue
);

  localparam int X_END = ORIGIN_X + (SCREEN_X << SCALE_LOG2);
  localparam int Y_END = ORIGIN_Y + (SCREEN_Y << SCALE_LOG2);

  // ---------------- stage 0: window test and address ----------------
  int px, py, lx, ly;
  logic in_x, in_y, in_win;
  logic [ADDR_W-1:0] addr_s0;

  assign px     = int'(posicionX);
  assign py     = int'(posicionY);
  assign in_x   = (px >= ORIGIN_X) && (px < X_END);
  assign in_y   = (py >= ORIGIN_Y) && (py < Y_END);
  assign in_win = in_x && in_y && visible;
  // Only meaningful while in_win, where the differences are non-negative.
  assign lx      = (px - ORIGIN_X) >>> SCALE_LOG2;
  assign ly      = (py - ORIGIN_Y) >>> SCALE_LOG2;
  assign addr_s0 = ADDR_W'(ly * SCREEN_X + lx);

  // ---------------- frame state ----------------
  logic                  frame_start;
  logic [BLINK_LOG2:0]   frame_cnt, frame_cnt_eff;
  logic [1:0]            modo_q, modo_eff;

  assign frame_start = (posicionX == 10'd0) && (posicionY == 10'd0);
  // The frame-start pixel already belongs to the new frame, so it sees the
  // freshly latched mode and incremented count.
  assign frame_cnt_eff = frame_start ? frame_cnt + 1'b1 : frame_cnt;
  assign modo_eff      = frame_start ? modo : modo_q;

  // Latch mode and advance the blink counter once per frame.
  always_ff @(posedge clock) begin
    if (!reset) begin
      frame_cnt <= '0;
      modo_q    <= 2'b00;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt_eff;
      modo_q    <= modo;
    end
  end

  pix_flags_t flags_s0, flags_s1, flags_al;

  // Per-pixel flags; reserved mode 11 decodes to neither invert nor blink.
  always_comb begin
    flags_s0     = '0;
    flags_s0.vis = visible;
    flags_s0.win = in_win;
    flags_s0.inv = (modo_eff == MODO_INVERT);
    flags_s0.brd = (modo_eff == MODO_BLINK) && frame_cnt_eff[BLINK_LOG2];
  end

  // ---------------- stage 1: address register ----------------
  // Address holds outside the window so the memory sees no spurious traffic.
  always_ff @(posedge clock) begin
    if (!reset) begin
      memAddress <= '0;
      flags_s1   <= '0;
    end else begin
      if (in_win) memAddress <= addr_s0;
      flags_s1 <= flags_s0;
    end
  end

  // Flags wait MEM_LATENCY more cycles so they meet readValueMemory.
  pipe_delay #(
    .WIDTH(PIX_FLAGS_W),
    .DEPTH(MEM_LATENCY)
  ) u_flag_dly (
    .clock(clock),
    .reset(reset),
    .din  (flags_s1),
    .dout (flags_al)
  );

  // ---------------- colour stage ----------------
  rgb_t rgb_q;

  // Blanking wins, then border/blink-off, then the mode-transformed pixel.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rgb_q <= COLOR_BLACK;
    end else if (!flags_al.vis) begin
      rgb_q <= COLOR_BLACK;
    end else if (!flags_al.win || flags_al.brd) begin
      rgb_q <= BORDER_COLOR;
    end else begin
      rgb_q <= expand_rgb(readValueMemory ^ {3{flags_al.inv}});
    end
  end

  assign red   = rgb_q[23:16];
  assign green = rgb_q[15:8];
  assign blue  = rgb_q[7:0];

endmodule

// File: doc/region_pantalla_param.md
# region_pantalla_param

Parametrised, pipelined successor to the fixed 50×50 screen-region colouriser in the VGA path. Sits between the VGA sync counter and the DAC. It maps each raster position to a framebuffer address inside a configurable, offset, integer-scaled window, and aligns the returned 3-bit pixel to the raster through a latency-matched pipeline. It drives a border colour outside the window, black during blanking, and supports a per-frame display mode (direct, inverted, blink).

## Interface
Parameters:
- SCREEN_X, 50, window width in framebuffer pixels
- SCREEN_Y, 50, window height in framebuffer pixels
- ORIGIN_X, 0, raster column of window's left edge
- ORIGIN_Y, 0, raster row of window's top edge
- SCALE_LOG2, 0, each framebuffer pixel drawn as 2^SCALE_LOG2 × 2^SCALE_LOG2 raster pixels
- MEM_LATENCY, 1, cycles from memAddress valid to readValueMemory valid (≥1)
- ADDR_W, 12, framebuffer address width; must satisfy 2^ADDR_W ≥ SCREEN_X·SCREEN_Y
- BORDER_COLOR, 24'hFFFFFF, {red,green,blue} driven outside window
- BLINK_LOG2, 5, blink half-period = 2^BLINK_LOG2 frames

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-low reset
- posicionX  in  10  raster column
- posicionY  in  10  raster row
- visible  in  1  high during active video
- modo  in  2  00 direct, 01 inverted, 10 blink, 11 reserved (treated as 00)
- memAddress  out  ADDR_W  framebuffer read address
- readValueMemory  in  3  pixel; bit0 red, bit1 green, bit2 blue
- red, green, blue  out  8 each  colour to DAC

## Operation
- Window test: inX = ORIGIN_X ≤ posicionX < ORIGIN_X + (SCREEN_X<<SCALE_LOG2); inY likewise. inWin = inX & inY & visible.
- Local coords: lx = (posicionX−ORIGIN_X)>>SCALE_LOG2, ly likewise. Address = ly·SCREEN_X + lx, truncated to ADDR_W. Computed only when inWin; otherwise memAddress holds its previous value.
- Pipeline carries {visible, inWin} alongside the address through 1+MEM_LATENCY stages so that the flags meet the returned data.
- Output colour: !visible → 0,0,0. visible & !inWin → BORDER_COLOR. inWin → each channel = 8'hFF if selected bit set else 8'h00, after mode transform.
- Mode transform: direct = bits as read. Inverted = bits complemented. Blink = direct when frame counter bit BLINK_LOG2 is 0, BORDER_COLOR for whole window when 1.
- Frame counter: increments once per frame on the cycle posicionX==0 && posicionY==0 and wraps at 2^(BLINK_LOG2+1).
- modo is sampled into an internal register only on that same frame-start cycle; a mid-frame change takes effect next frame (no tearing).
- Reserved modo 11 behaves as direct.

## Timing
- memAddress registered: valid 1 cycle after the posicion sample.
- red/green/blue registered: total latency posicion → colour = 2 + MEM_LATENCY cycles (3 at default). Latency is constant for all paths (blanking, border, window).
- Reset (reset==0 at clock edge): red/green/blue = 0, memAddress = 0, all pipeline flags = 0 (blanking), frame counter = 0, latched mode = 00. Reset mid-frame: outputs are black until the pipeline refills (2+MEM_LATENCY cycles after release).
- Frame start coinciding with a mode change: the new modo is latched and the counter increments in the same cycle.
- Window edges are exact: the last in-window column is ORIGIN_X+(SCREEN_X<<SCALE_LOG2)−1.
- Window extending past 639/479 is clipped naturally by visible.

## Structure
- Shared package vga_pkg: mode enum (MODO_DIRECT, MODO_INVERT, MODO_BLINK), colour constants (COLOR_BLACK, COLOR_WHITE), 24-bit rgb_t typedef.
- Sub-module pipe_delay (parametrised width/depth shift register) aligns the {visible, inWin} flags with memory latency; reusable elsewhere in the VGA path.

## Test plan
- Defaults, model memory returning addr[2:0], posicion (0,0) visible → after 3 cycles RGB = FF,00,00? Check: address 0 → data 000 → 00,00,00. At (1,0), data 001 → FF,00,00 three cycles later.
- SCALE_LOG2=1, ORIGIN=(100,50): posicion (101,51) → memAddress 0; (102,50) → 1; (100,52) → SCREEN_X; (99,50) → BORDER_COLOR.
- visible=0 inside window → 00,00,00; memAddress unchanged.
- modo=01 switched mid-frame → still direct until the next (0,0), then data 101 shows 00,FF,00.
- modo=10, BLINK_LOG2=1: window shows data for frames 0–1 and BORDER_COLOR for frames 2–3, then repeats.
- MEM_LATENCY=3: colour latency 5 cycles; reset asserted mid-line → all outputs 0 next edge, black for 5 cycles after release.
